// File: rtl/vga_stream_tx.sv
// Valid/ready RGB444 pixel stream to registered VGA timing, with sof-based frame lock.
// Optional colour-bar generator is built only when VGA_TEST_PATTERN_EN is defined.
module vga_stream_tx #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic [11:0] in_rgb,
  input  logic        in_sof,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        pattern_sel,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        locked,
  output logic        err_underrun,
  output logic        err_sync
);

  localparam int unsigned HT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned MAXT = (HT > VT) ? HT : VT;
  localparam int unsigned CW   = $clog2(MAXT);

  localparam logic [CW-1:0] HLast    = CW'(HT - 1);
  localparam logic [CW-1:0] VLast    = CW'(VT - 1);
  localparam logic [CW-1:0] HActC    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VActC    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HsStart  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HsEnd    = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VsStart  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VsEnd    = CW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic          active, at_origin, hsync_on, vsync_on;
  logic [11:0]   pix_d;
  logic          set_under, set_sync;

  assign active    = (hcnt_q < HActC) && (vcnt_q < VActC);
  assign at_origin = (hcnt_q == '0) && (vcnt_q == '0);
  assign hsync_on  = (hcnt_q >= HsStart) && (hcnt_q < HsEnd);
  assign vsync_on  = (vcnt_q >= VsStart) && (vcnt_q < VsEnd);
  assign locked    = (state_q == StLocked);

  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == HLast) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 1'b1;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BarW = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [CW-1:0] bar_pos;
  logic [2:0]    bar_idx;
  logic [11:0]   bar_rgb;

  assign bar_pos = hcnt_q / CW'(BarW);
  assign bar_idx = bar_pos[2:0];

  always_comb begin
    bar_rgb = 12'h000;
    unique case (bar_idx)
      3'd0:    bar_rgb = 12'hFFF;
      3'd1:    bar_rgb = 12'hFF0;
      3'd2:    bar_rgb = 12'h0FF;
      3'd3:    bar_rgb = 12'h0F0;
      3'd4:    bar_rgb = 12'hF0F;
      3'd5:    bar_rgb = 12'hF00;
      3'd6:    bar_rgb = 12'h00F;
      default: bar_rgb = 12'h000;
    endcase
  end
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
`endif

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    pix_d     = 12'h000;
    set_under = 1'b0;
    set_sync  = 1'b0;
    unique case (state_q)
      StHunt: begin
        // A sof beat is held off until the raster reaches (0,0).
        in_ready = in_sof ? at_origin : 1'b1;
        if (in_valid && in_sof && at_origin) begin
          pix_d   = in_rgb;
          state_d = StLocked;
        end
      end
      StLocked: begin
        // Refuse any beat whose sof flag disagrees with the raster position.
        in_ready = active && (in_sof == at_origin);
        if (active) begin
          if (!in_valid) begin
            set_under = 1'b1;
            state_d   = StHunt;
          end else if (in_sof != at_origin) begin
            set_sync = 1'b1;
            state_d  = StHunt;
          end else begin
            pix_d = in_rgb;
          end
        end
      end
      default: state_d = StHunt;
    endcase
`ifdef VGA_TEST_PATTERN_EN
    if (pattern_sel) begin
      state_d   = StHunt;
      in_ready  = 1'b0;
      set_under = 1'b0;
      set_sync  = 1'b0;
      pix_d     = active ? bar_rgb : 12'h000;
    end
`endif
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StHunt;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      r            <= 4'h0;
      g            <= 4'h0;
      b            <= 4'h0;
      hsync        <= !SYNC_POL;
      vsync        <= !SYNC_POL;
      frame_start  <= 1'b0;
      err_underrun <= 1'b0;
      err_sync     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      r            <= pix_d[11:8];
      g            <= pix_d[7:4];
      b            <= pix_d[3:0];
      hsync        <= hsync_on ? SYNC_POL : !SYNC_POL;
      vsync        <= vsync_on ? SYNC_POL : !SYNC_POL;
      frame_start  <= at_origin;
      err_underrun <= err_underrun | set_under;
      err_sync     <= err_sync | set_sync;
    end
  end

endmodule
